pmem_ctrl: RTL
==============

# pmem_ctrl

Sequencer and port arbiter for the program-memory block. It shares the single word-addressed memory port between instruction fetch and a 16-bit halfword loader. It assembles loader halfword pairs into 32-bit words and writes them to consecutive word addresses. While a load runs it holds the core and stalls fetch; otherwise it forwards the fetch address with a registered valid aligned to the memory's one-cycle read latency.

## Interface
Parameters:
- ADDR_W, 15, word-address width (32768 words)

Ports (reset is asynchronous, active-low):
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- fetch_req_c0  in  1  core requests an instruction this cycle
- pc_read_c0  in  32  fetch byte address; bits [1:0] and [31:ADDR_W+2] ignored
- fetch_stall_c0  out  1  fetch not served this cycle
- instr_valid_c1  out  1  memory read data this cycle is a served fetch
- mem_addr_c0  out  ADDR_W  word address to program memory
- mem_we_c0  out  1  write strobe to program memory
- mem_wdata_c0  out  32  write data, {high half, low half}
- ld_start  in  1  pulse: begin a load session
- ld_base  in  ADDR_W  first word address, sampled on accepted ld_start
- ld_count  in  ADDR_W+1  word count, sampled on accepted ld_start
- ld_valid  in  1  loader halfword valid
- ld_half  in  16  loader halfword
- ld_ready  out  1  controller accepts halfword
- ld_busy  out  1  load session active (state != IDLE)
- ld_done  out  1  one-cycle pulse at session end
- core_hold  out  1  keep core halted; equals ld_busy

## Operation
- States: IDLE, LO, HI, WR, DONE. The controller holds registers ptr[ADDR_W], remain[ADDR_W+1], lo[16] and hi[16].
- IDLE:
  - mem_addr_c0 = pc_read_c0[ADDR_W+1:2] (combinational); mem_we_c0=0; fetch_stall_c0=0; ld_ready=0.
  - On ld_start: ptr<=ld_base, remain<=ld_count. Next state is DONE if ld_count==0, else LO.
- LO: ld_ready=1. On ld_valid&ld_ready: lo<=ld_half, go to HI. Otherwise stay.
- HI: ld_ready=1. On ld_valid&ld_ready: hi<=ld_half, go to WR. Otherwise stay.
- WR:
  - ld_ready=0; mem_we_c0=1; mem_addr_c0=ptr; mem_wdata_c0={hi,lo}.
  - ptr<=ptr+1, wrapping modulo 2^ADDR_W; remain<=remain-1.
  - Next state is DONE if remain==1, else LO.
- DONE: ld_done=1 for exactly this cycle; go to IDLE.
- Outside IDLE:
  - mem_addr_c0=ptr; fetch_stall_c0=fetch_req_c0; core_hold=1.
  - Fetch requests are dropped, not queued.
- mem_we_c0=1 only in WR. mem_wdata_c0={hi,lo} in all states; it is don't-care when mem_we_c0=0.
- ld_start outside IDLE is ignored: no re-sample, no state change.
- Simultaneous ld_start and fetch_req_c0 in IDLE: the fetch is served that cycle (stall=0, valid next cycle), and the load begins next cycle.
- A halfword with ld_valid in WR/DONE/IDLE is not consumed; the loader holds it until ld_ready.
- reset_n low at any time, including mid-load: immediate return to IDLE.
  - Partial words are discarded and nothing further is written.
  - Register reset values: ptr=0, remain=0, lo=0, hi=0, instr_valid_c1=0.
  - Output values under reset: ld_done=0, mem_we_c0=0, ld_ready=0, ld_busy=0, core_hold=0, fetch_stall_c0=0; mem_addr_c0 follows pc_read_c0.

## Timing
- Fetch: address presented combinationally in cycle c0. instr_valid_c1 <= (state==IDLE)&fetch_req_c0, registered, so it coincides with the memory's registered read data in c1.
- Load throughput: minimum 3 cycles per word (LO, HI, WR) with ld_valid held high.
- N-word session from ld_start at cycle t, loader always valid:
  - writes occur at t+3, t+6, …, t+3N;
  - ld_done at t+3N+1;
  - IDLE (fetch served) at t+3N+2.
- ld_count==0: ld_done at t+1, IDLE at t+2, no writes.
- The first cycle after the session leaves IDLE has fetch_stall_c0=1 if fetch_req_c0=1, and instr_valid_c1=0 in the following cycle.

## Test plan
- Fetch-only:
  - Stimulus: fetch_req_c0=1, pc_read_c0=0x0000_0010, then 0x0000_0014.
  - Response: mem_addr_c0=4 then 5; instr_valid_c1=1 one cycle later each; stall=0 throughout.
- Two-word load:
  - Stimulus: ld_base=0x100, ld_count=2, halfwords 0x1111, 0x2222, 0x3333, 0x4444 back-to-back.
  - Response: write 0x2222_1111@0x100 at t+3 and 0x4444_3333@0x101 at t+6; ld_done at t+7; core_hold high t+1..t+7.
- Wrap and backpressure:
  - Stimulus: ld_base=0x7FFF, ld_count=2, with ld_valid gapped 2 cycles between halves.
  - Response: writes at 0x7FFF then 0x0000; ld_ready stays high while waiting; no extra writes.
- Contention:
  - Stimulus: ld_start with fetch_req_c0=1 in the same cycle, then fetch held during the load.
  - Response: the first fetch is served with valid; subsequent fetches show stall=1 and valid=0 until IDLE returns.
- Zero count / ignored start:
  - Stimulus: ld_count=0; then ld_start re-pulsed during an active load.
  - Response: for ld_count=0, ld_done at t+1 with no mem_we_c0. The mid-load pulse does not change ptr or remain.
- Reset mid-load:
  - Stimulus: reset_n low while in HI.
  - Response: all outputs at reset values immediately; no write follows after release; fetch is served on the first cycle after release.

Source files
------------

// File: rtl/pmem_if.sv
// pmem_if: fetch, program-memory and halfword-loader signals of the program-memory sequencer.
interface pmem_if #(parameter int ADDR_W = 15);
  logic              fetch_req_c0;
  logic [31:0]       pc_read_c0;
  logic              fetch_stall_c0;
  logic              instr_valid_c1;
  logic [ADDR_W-1:0] mem_addr_c0;
  logic              mem_we_c0;
  logic [31:0]       mem_wdata_c0;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic [ADDR_W:0]   ld_count;
  logic              ld_valid;
  logic [15:0]       ld_half;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;
  logic              core_hold;
  modport master (
    output fetch_req_c0, pc_read_c0, ld_start, ld_base, ld_count, ld_valid, ld_half,
    input  fetch_stall_c0, instr_valid_c1, mem_addr_c0, mem_we_c0, mem_wdata_c0,
           ld_ready, ld_busy, ld_done, core_hold
  );
  modport slave (
    input  fetch_req_c0, pc_read_c0, ld_start, ld_base, ld_count, ld_valid, ld_half,
    output fetch_stall_c0, instr_valid_c1, mem_addr_c0, mem_we_c0, mem_wdata_c0,
           ld_ready, ld_busy, ld_done, core_hold
  );
endinterface

// File: rtl/pmem_ctrl.sv
// pmem_ctrl: shares the program-memory port between instruction fetch and a halfword loader
// that packs halfword pairs into words written to consecutive addresses.
module pmem_ctrl #(
  parameter int ADDR_W = 15
) (
  input logic   clk,
  input logic   reset_n,
  pmem_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LO, HI, WR, DONE} state_t;
  state_t            state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remain;
  logic [15:0]       lo, hi;
  logic              idle;
  logic              unused_pc;
  assign idle = state == IDLE;
  assign unused_pc = ^{bus.pc_read_c0[31:ADDR_W+2], bus.pc_read_c0[1:0]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      ptr                <= '0;
      remain             <= '0;
      lo                 <= '0;
      hi                 <= '0;
      bus.instr_valid_c1 <= 1'b0;
    end else begin
      state              <= state_n;
      bus.instr_valid_c1 <= idle && bus.fetch_req_c0;
      if (idle && bus.ld_start) begin
        ptr    <= bus.ld_base;
        remain <= bus.ld_count;
      end
      if (state == LO && bus.ld_valid) lo <= bus.ld_half;
      if (state == HI && bus.ld_valid) hi <= bus.ld_half;
      if (state == WR) begin
        ptr    <= ptr + 1'b1;
        remain <= remain - 1'b1;
      end
    end
  end
  always_comb begin
    state_n            = state;
    bus.ld_ready       = state == LO || state == HI;
    bus.mem_we_c0      = state == WR;
    bus.mem_addr_c0    = idle ? bus.pc_read_c0[ADDR_W+1:2] : ptr;
    bus.mem_wdata_c0   = {hi, lo};
    bus.fetch_stall_c0 = !idle && bus.fetch_req_c0;
    bus.ld_busy        = !idle;
    bus.core_hold      = !idle;
    bus.ld_done        = state == DONE;
    case (state)
      IDLE:    if (bus.ld_start) state_n = bus.ld_count == '0 ? DONE : LO;
      LO:      if (bus.ld_valid) state_n = HI;
      HI:      if (bus.ld_valid) state_n = WR;
      WR:      state_n = remain == 1 ? DONE : LO;
      default: state_n = IDLE;
    endcase
  end
endmodule
